// File: rtl/conv_mac_sequencer.sv
// conv_mac_sequencer: loads a KxK filter, a bias word and an RxC input matrix
// over one stream, then walks every valid-window output position through an
// external MAC and returns each accumulator result on an output stream.
//
// Handshakes: a word moves on a stream only in a cycle where both valid and
// ready are high at the rising edge of clk. A producer never retracts valid or
// changes data before that transfer. Ready and valid are decoded from state
// only. Neither depends combinationally on the other side's signal.
module conv_mac_sequencer #(
  parameter int INW  = 16,
  parameter int OUTW = 64,
  parameter int R    = 8,
  parameter int C    = 8,
  parameter int K    = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [INW-1:0]  s_data,
  input  logic            s_valid,
  output logic            s_ready,
  output logic [INW-1:0]  mac_input0,
  output logic [INW-1:0]  mac_input1,
  output logic [INW-1:0]  mac_init_value,
  output logic            mac_init_acc,
  output logic            mac_input_valid,
  input  logic [OUTW-1:0] mac_out,
  output logic [OUTW-1:0] m_data,
  output logic            m_valid,
  input  logic            m_ready
);

  localparam int KK   = K * K;
  localparam int NPIX = R * C;
  localparam int OR_N = R - K + 1;
  localparam int OC_N = C - K + 1;

  // Counter widths: enough bits for 0..max-1, never narrower than one bit.
  localparam int KW  = (K    > 1) ? $clog2(K)    : 1;
  localparam int WAW = (KK   > 1) ? $clog2(KK)   : 1;
  localparam int XAW = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int ORW = (OR_N > 1) ? $clog2(OR_N) : 1;
  localparam int OCW = (OC_N > 1) ? $clog2(OC_N) : 1;

  localparam logic [KW-1:0]  K_LAST  = KW'(K - 1);
  localparam logic [WAW-1:0] W_LAST  = WAW'(KK - 1);
  localparam logic [XAW-1:0] X_LAST  = XAW'(NPIX - 1);
  localparam logic [ORW-1:0] OR_LAST = ORW'(OR_N - 1);
  localparam logic [OCW-1:0] OC_LAST = OCW'(OC_N - 1);

  localparam logic [2:0] LOAD_W = 3'd0;
  localparam logic [2:0] LOAD_B = 3'd1;
  localparam logic [2:0] LOAD_X = 3'd2;
  localparam logic [2:0] INIT   = 3'd3;
  localparam logic [2:0] ACC    = 3'd4;
  localparam logic [2:0] OUT    = 3'd5;

  // state is visible by name for checkers bound to this module
  logic [2:0]     state;
  logic [WAW-1:0] w_cnt;
  logic [XAW-1:0] x_cnt;
  logic [KW-1:0]  tap_i;
  logic [KW-1:0]  tap_j;
  logic [ORW-1:0] orow;
  logic [OCW-1:0] ocol;

  logic [INW-1:0] bias_q;
  logic [INW-1:0] w_mem [KK];
  logic [INW-1:0] x_mem [NPIX];

  logic [WAW-1:0] w_addr;
  logic [XAW-1:0] x_addr;
  logic           load_fire;
  logic           out_fire;

  assign load_fire = s_valid && s_ready;
  assign out_fire  = m_valid && m_ready;

  // Sequencing FSM: load counters, tap counters and output-position counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD_W;
      w_cnt <= '0;
      x_cnt <= '0;
      tap_i <= '0;
      tap_j <= '0;
      orow  <= '0;
      ocol  <= '0;
    end else begin
      case (state)
        LOAD_W: begin
          if (load_fire) begin
            if (w_cnt == W_LAST) begin
              w_cnt <= '0;
              state <= LOAD_B;
            end else begin
              w_cnt <= w_cnt + WAW'(1);
            end
          end
        end
        LOAD_B: begin
          if (load_fire) state <= LOAD_X;
        end
        LOAD_X: begin
          if (load_fire) begin
            if (x_cnt == X_LAST) begin
              x_cnt <= '0;
              orow  <= '0;
              ocol  <= '0;
              state <= INIT;
            end else begin
              x_cnt <= x_cnt + XAW'(1);
            end
          end
        end
        INIT: begin
          tap_i <= '0;
          tap_j <= '0;
          state <= ACC;
        end
        ACC: begin
          if (tap_j == K_LAST) begin
            tap_j <= '0;
            if (tap_i == K_LAST) begin
              tap_i <= '0;
              state <= OUT;
            end else begin
              tap_i <= tap_i + KW'(1);
            end
          end else begin
            tap_j <= tap_j + KW'(1);
          end
        end
        OUT: begin
          if (out_fire) begin
            if (ocol == OC_LAST) begin
              ocol <= '0;
              if (orow == OR_LAST) begin
                orow  <= '0;
                state <= LOAD_W;
              end else begin
                orow  <= orow + ORW'(1);
                state <= INIT;
              end
            end else begin
              ocol  <= ocol + OCW'(1);
              state <= INIT;
            end
          end
        end
        default: state <= LOAD_W;
      endcase
    end
  end

  // Operand storage; contents are don't-care until a full problem is loaded
  always_ff @(posedge clk) begin
    if (load_fire && state == LOAD_W) w_mem[w_cnt] <= s_data;
    if (load_fire && state == LOAD_B) bias_q <= s_data;
    if (load_fire && state == LOAD_X) x_mem[x_cnt] <= s_data;
  end

  // Row-major read addresses for the current tap of the current window
  always_comb begin
    w_addr = WAW'(int'(tap_i) * K + int'(tap_j));
    x_addr = XAW'((int'(orow) + int'(tap_i)) * C + int'(ocol) + int'(tap_j));
  end

  // Output decode: everything is a function of state, counters and storage
  always_comb begin
    s_ready         = 1'b0;
    m_valid         = 1'b0;
    mac_init_acc    = 1'b0;
    mac_input_valid = 1'b0;
    mac_input0      = '0;
    mac_input1      = '0;
    mac_init_value  = bias_q;
    m_data          = mac_out;
    case (state)
      LOAD_W, LOAD_B, LOAD_X: s_ready = 1'b1;
      INIT: mac_init_acc = 1'b1;
      ACC: begin
        mac_input_valid = 1'b1;
        mac_input0      = x_mem[x_addr];
        mac_input1      = w_mem[w_addr];
      end
      OUT: m_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Directed bench for conv_mac_sequencer (R=C=4, K=3) with a behavioural MAC.
module tb_conv_mac_sequencer;

  localparam int INW  = 16;
  localparam int OUTW = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [INW-1:0]  s_data = '0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [INW-1:0]  mac_input0, mac_input1, mac_init_value;
  logic            mac_init_acc, mac_input_valid;
  logic [OUTW-1:0] mac_out;
  logic [OUTW-1:0] m_data;
  logic            m_valid;
  logic            m_ready = 1'b1;

  conv_mac_sequencer #(.INW(INW), .OUTW(OUTW), .R(4), .C(4), .K(3)) dut (
    .clk(clk), .reset(reset),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .mac_input0(mac_input0), .mac_input1(mac_input1),
    .mac_init_value(mac_init_value), .mac_init_acc(mac_init_acc),
    .mac_input_valid(mac_input_valid), .mac_out(mac_out),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  // ---------------- behavioural MAC ----------------
  logic signed [OUTW-1:0] x_ext, w_ext, b_ext, prod;
  always_comb begin
    x_ext = {{(OUTW-INW){mac_input0[INW-1]}}, mac_input0};
    w_ext = {{(OUTW-INW){mac_input1[INW-1]}}, mac_input1};
    b_ext = {{(OUTW-INW){mac_init_value[INW-1]}}, mac_init_value};
    prod  = x_ext * w_ext;
  end
  always @(posedge clk) begin
    if (reset)                mac_out <= '0;
    else if (mac_init_acc)    mac_out <= b_ext;
    else if (mac_input_valid) mac_out <= mac_out + prod;
  end

  // ---------------- scoreboard ----------------
  logic [OUTW-1:0] exp_q[$];
  int rise_q[$];
  int passed = 0;
  int total  = 0;
  logic mv_d = 1'b0;
  logic [OUTW-1:0] exp_d;

  task automatic check(input string tag, input logic [OUTW-1:0] obs, input logic [OUTW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Result monitor: every transfer must match the head of the expected queue
  always @(negedge clk) begin
    if (!reset) begin
      if (m_valid && !mv_d) rise_q.push_back(cyc);
      if (m_valid && m_ready) begin
        check("result_expected", OUTW'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_d = exp_q.pop_front();
          check("m_data", m_data, exp_d);
        end
      end
    end
    mv_d = m_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d passed=%0d", total, passed);
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [INW-1:0] d, input bit stall, output int acc_cyc);
    int budget;
    if (stall) begin
      repeat ($urandom_range(0, 2)) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    s_valid = 1'b1;
    s_data  = d;
    budget  = 0;
    @(negedge clk);
    while (!s_ready && budget < 50) begin
      budget++;
      @(negedge clk);
    end
    if (!s_ready) check("load_accept", OUTW'(s_ready), 1);
    acc_cyc = cyc;
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  // xmode 0: X = 1..16 row-major; xmode 1: X constant xval
  task automatic load_problem(input logic [INW-1:0] wval, input logic [INW-1:0] bval,
                              input int xmode, input logic [INW-1:0] xval,
                              input bit stall, output int last_acc);
    int c;
    for (int i = 0; i < 9; i++) send_word(wval, stall, c);
    send_word(bval, stall, c);
    for (int i = 0; i < 16; i++)
      send_word((xmode == 0) ? INW'(i + 1) : xval, stall, c);
    last_acc = c;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain", OUTW'(exp_q.size()), 0);
    @(posedge clk); #1;
  endtask

  task automatic push4(input logic [OUTW-1:0] a, input logic [OUTW-1:0] b,
                       input logic [OUTW-1:0] c, input logic [OUTW-1:0] d);
    exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c); exp_q.push_back(d);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int last_acc;
    int n;

    // reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_s_ready", OUTW'(s_ready), 1);
    check("rst_m_valid", OUTW'(m_valid), 0);
    check("rst_init_acc", OUTW'(mac_init_acc), 0);
    check("rst_input_valid", OUTW'(mac_input_valid), 0);
    check("rst_input0", OUTW'(mac_input0), 0);
    check("rst_input1", OUTW'(mac_input1), 0);
    @(posedge clk); #1;

    // 1: ones filter over 1..16
    push4(54, 63, 90, 99);
    load_problem(16'd1, 16'd0, 0, 16'd0, 1'b0, last_acc);
    wait_drain(300);
    @(negedge clk);
    check("s1_s_ready_after", OUTW'(s_ready), 1);
    @(posedge clk); #1;

    // 2: negative filter with bias
    push4(82, 82, 82, 82);
    load_problem(16'hFFFF, 16'd100, 1, 16'd2, 1'b0, last_acc);
    wait_drain(300);
    @(negedge clk);
    check("s2_init_value", OUTW'(mac_init_value), 100);
    @(posedge clk); #1;

    // 3: extreme operands
    push4(64'd9663676416, 64'd9663676416, 64'd9663676416, 64'd9663676416);
    load_problem(16'h8000, 16'd0, 1, 16'h8000, 1'b0, last_acc);
    wait_drain(300);

    // 4: backpressure on the first result
    m_ready = 1'b0;
    push4(54, 63, 90, 99);
    load_problem(16'd1, 16'd0, 0, 16'd0, 1'b0, last_acc);
    n = 0;
    @(negedge clk);
    while (!m_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    for (int k = 0; k < 5; k++) begin
      if (k != 0) @(negedge clk);
      check("bp_m_valid", OUTW'(m_valid), 1);
      check("bp_m_data", m_data, 54);
      check("bp_input_valid", OUTW'(mac_input_valid), 0);
      check("bp_init_acc", OUTW'(mac_init_acc), 0);
      check("bp_s_ready", OUTW'(s_ready), 0);
    end
    check("bp_no_pop", OUTW'(exp_q.size()), 4);
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_drain(300);

    // 5: stalled load, latency and output spacing
    rise_q.delete();
    push4(54, 63, 90, 99);
    load_problem(16'd1, 16'd0, 0, 16'd0, 1'b1, last_acc);
    wait_drain(300);
    check("s5_pulses", OUTW'(rise_q.size()), 4);
    if (rise_q.size() >= 4) begin
      check("s5_first_latency", OUTW'(rise_q[0] - last_acc), 11);
      check("s5_gap1", OUTW'(rise_q[1] - rise_q[0]), 11);
      check("s5_gap2", OUTW'(rise_q[2] - rise_q[1]), 11);
      check("s5_gap3", OUTW'(rise_q[3] - rise_q[2]), 11);
    end

    // 6: reset in the middle of ACC, then scenario 2
    load_problem(16'd1, 16'd0, 0, 16'd0, 1'b0, last_acc);
    n = 0;
    @(negedge clk);
    while (!mac_input_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("s6_in_acc", OUTW'(mac_input_valid), 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    rise_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("s6_s_ready", OUTW'(s_ready), 1);
    check("s6_init_acc", OUTW'(mac_init_acc), 0);
    check("s6_input_valid", OUTW'(mac_input_valid), 0);
    check("s6_m_valid", OUTW'(m_valid), 0);
    check("s6_input0", OUTW'(mac_input0), 0);
    check("s6_input1", OUTW'(mac_input1), 0);
    @(posedge clk); #1;
    push4(82, 82, 82, 82);
    load_problem(16'hFFFF, 16'd100, 1, 16'd2, 1'b0, last_acc);
    wait_drain(300);
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("s6_outputs", OUTW'(rise_q.size()), 4);
    check("s6_idle_m_valid", OUTW'(m_valid), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
